// File: rtl/lock_pkg.sv
// Shared types and helpers for the lock key loader: FSM states, default key width,
// frame parity and the key-bit to core key-input mapping.
package lock_pkg;

    localparam int unsigned KEY_W_DEF = 12;

    // key[i] drives core key input s_{i + KEY_S_BASE}
    localparam int unsigned KEY_S_BASE = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CHECK,
        ST_LOADED,
        ST_ERROR
    } state_e;

    // XOR of every frame bit; zero means the frame has even parity
    function automatic logic frame_parity(input logic [63:0] bits);
        return ^bits;
    endfunction

    function automatic int unsigned s_index(input int unsigned key_bit);
        return key_bit + KEY_S_BASE;
    endfunction

endpackage

// File: rtl/lock_key_shreg.sv
// LSB-first frame shift register (data bits then parity) with a count of bits taken.
module lock_key_shreg #(
    parameter int unsigned KEY_W = 12,
    localparam int unsigned CNT_W = $clog2(KEY_W + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             sdi,
    output logic [KEY_W:0]   data,
    output logic [CNT_W-1:0] cnt
);

    logic [KEY_W:0]   data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // New bits enter at the top so the first bit ends up in data[0]
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (clr) begin
            data_d = '0;
            cnt_d  = '0;
        end else if (shift_en) begin
            data_d = {sdi, data_q[KEY_W:1]};
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data = data_q;
    assign cnt  = cnt_q;

endmodule

// File: rtl/lock_key_loader.sv
// Serial key frame receiver for a logic-locked core: checks parity and inter-bit gap,
// then holds the accepted key on a registered parallel bus (all zeros until then).
module lock_key_loader
    import lock_pkg::*;
#(
    parameter int unsigned KEY_W     = KEY_W_DEF,
    parameter int unsigned TIMEOUT   = 64,
    parameter bit          RELOAD_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sdi,
    input  logic             sdi_valid,
    output logic [KEY_W-1:0] key,
    output logic             key_ready,
    output logic             key_err,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(KEY_W + 2);
    localparam int unsigned GAP_W = $clog2(TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             key_ready_q, key_ready_d;
    logic             key_err_q, key_err_d;
    logic             busy_q, busy_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    logic             sr_clr;
    logic             sr_shift;
    logic [KEY_W:0]   sr_data;
    logic [CNT_W-1:0] sr_cnt;

    lock_key_shreg #(
        .KEY_W (KEY_W)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .clr      (sr_clr),
        .shift_en (sr_shift),
        .sdi      (sdi),
        .data     (sr_data),
        .cnt      (sr_cnt)
    );

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        key_ready_d = key_ready_q;
        key_err_d   = key_err_q;
        gap_d       = gap_q;
        sr_clr      = 1'b0;
        sr_shift    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SHIFT;
                    sr_clr    = 1'b1;
                    gap_d     = '0;
                    key_err_d = 1'b0;
                end
            end

            ST_SHIFT: begin
                if (start) begin
                    sr_clr = 1'b1;
                    gap_d  = '0;
                end else if (sdi_valid) begin
                    sr_shift = 1'b1;
                    gap_d    = '0;
                    if (sr_cnt == CNT_W'(KEY_W)) begin
                        state_d = ST_CHECK;
                    end
                end else begin
                    if (gap_q != GAP_W'(TIMEOUT)) begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                    // This idle cycle is the TIMEOUT-th in a row
                    if (gap_q == GAP_W'(TIMEOUT - 1)) begin
                        state_d   = ST_ERROR;
                        key_d     = '0;
                        key_ready_d = 1'b0;
                        key_err_d = 1'b1;
                    end
                end
            end

            ST_CHECK: begin
                if (frame_parity(64'(sr_data)) == 1'b0) begin
                    state_d     = ST_LOADED;
                    key_ready_d = 1'b1;
                    for (int unsigned i = 0; i < KEY_W; i++) begin
                        key_d[s_index(i)] = sr_data[i];
                    end
                end else begin
                    state_d     = ST_ERROR;
                    key_d       = '0;
                    key_ready_d = 1'b0;
                    key_err_d   = 1'b1;
                end
            end

            ST_LOADED: begin
                // Reloading relocks the core until the new frame checks out
                if (start && RELOAD_EN) begin
                    state_d     = ST_SHIFT;
                    sr_clr      = 1'b1;
                    gap_d       = '0;
                    key_d       = '0;
                    key_ready_d = 1'b0;
                end
            end

            ST_ERROR: begin
                key_d       = '0;
                key_ready_d = 1'b0;
                if (start) begin
                    state_d   = ST_SHIFT;
                    sr_clr    = 1'b1;
                    gap_d     = '0;
                    key_err_d = 1'b0;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                key_d       = '0;
                key_ready_d = 1'b0;
                key_err_d   = 1'b0;
                gap_d       = '0;
            end
        endcase

        busy_d = (state_d == ST_SHIFT) || (state_d == ST_CHECK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            key_q       <= '0;
            key_ready_q <= 1'b0;
            key_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            key_ready_q <= key_ready_d;
            key_err_q   <= key_err_d;
            busy_q      <= busy_d;
            gap_q       <= gap_d;
        end
    end

    assign key       = key_q;
    assign key_ready = key_ready_q;
    assign key_err   = key_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_lock_key_loader.sv
// Bench for lock_key_loader: one-time (RELOAD_EN=0) and reloadable instances share stimulus;
// frame outcomes are queued per instance and compared when busy drops.
module tb_lock_key_loader;

    typedef struct packed {
        logic [11:0] key;
        logic        ready;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        sdi = 1'b0;
    logic        sdi_valid = 1'b0;
    logic [11:0] key0, key1;
    logic        key_ready0, key_ready1;
    logic        key_err0, key_err1;
    logic        busy0, busy1;

    int total = 0;
    int bad   = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic busy0_prev = 1'b0;
    logic busy1_prev = 1'b0;

    always #5 clk = ~clk;

    lock_key_loader #(.KEY_W(12), .TIMEOUT(64), .RELOAD_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .sdi(sdi), .sdi_valid(sdi_valid),
        .key(key0), .key_ready(key_ready0), .key_err(key_err0), .busy(busy0)
    );

    lock_key_loader #(.KEY_W(12), .TIMEOUT(64), .RELOAD_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .sdi(sdi), .sdi_valid(sdi_valid),
        .key(key1), .key_ready(key_ready1), .key_err(key_err1), .busy(busy1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame end (busy falling) pops the next expected outcome for that instance
    always @(negedge clk) begin
        exp_t e;
        if (busy0_prev && !busy0) begin
            if (q0.size() == 0) check_eq("sb0_unexpected_end", 32'(q0.size()), 32'd1);
            else begin
                e = q0.pop_front();
                check_eq("sb0_key", 32'(key0), 32'(e.key));
                check_eq("sb0_ready", 32'(key_ready0), 32'(e.ready));
                check_eq("sb0_err", 32'(key_err0), 32'(e.err));
            end
        end
        if (busy1_prev && !busy1) begin
            if (q1.size() == 0) check_eq("sb1_unexpected_end", 32'(q1.size()), 32'd1);
            else begin
                e = q1.pop_front();
                check_eq("sb1_key", 32'(key1), 32'(e.key));
                check_eq("sb1_ready", 32'(key_ready1), 32'(e.ready));
                check_eq("sb1_err", 32'(key_err1), 32'(e.err));
            end
        end
        busy0_prev = busy0;
        busy1_prev = busy1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        sdi_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        sdi_valid = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        sdi = b;
        sdi_valid = 1'b1;
        tick();
        sdi_valid = 1'b0;
    endtask

    // Sends frame bits lo..hi (bit 12 is parity), optional random idle before each
    task automatic send_range(input logic [12:0] f, input int lo, input int hi, input int maxgap);
        for (int i = lo; i <= hi; i++) begin
            if (maxgap > 0) idle($urandom_range(0, maxgap));
            send_bit(f[i]);
        end
    endtask

    function automatic logic [12:0] mk_frame(input logic [11:0] d, input logic flip);
        return {(^d) ^ flip, d};
    endfunction

    task automatic push_both(input exp_t e);
        q0.push_back(e);
        q1.push_back(e);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_key0"}, 32'(key0), 32'h0);
        check_eq({tag, "_ready0"}, 32'(key_ready0), 32'h0);
        check_eq({tag, "_err0"}, 32'(key_err0), 32'h0);
        check_eq({tag, "_busy0"}, 32'(busy0), 32'h0);
        check_eq({tag, "_key1"}, 32'(key1), 32'h0);
        check_eq({tag, "_ready1"}, 32'(key_ready1), 32'h0);
        check_eq({tag, "_err1"}, 32'(key_err1), 32'h0);
        check_eq({tag, "_busy1"}, 32'(busy1), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check_idle_outputs("reset");

        // Good frame and key_ready latency
        push_both('{key: 12'hA5C, ready: 1'b1, err: 1'b0});
        pulse_start();
        send_range(mk_frame(12'hA5C, 1'b0), 0, 12, 0);
        check_eq("check_cycle_ready", 32'(key_ready0), 32'h0);
        check_eq("check_cycle_busy", 32'(busy0), 32'h1);
        tick();
        check_eq("loaded_ready", 32'(key_ready0), 32'h1);
        check_eq("loaded_key", 32'(key0), 32'hA5C);
        idle(3);

        // Bad parity then recovery
        do_reset();
        push_both('{key: 12'h000, ready: 1'b0, err: 1'b1});
        pulse_start();
        send_range(mk_frame(12'hA5C, 1'b1), 0, 12, 0);
        idle(3);
        push_both('{key: 12'hA5C, ready: 1'b1, err: 1'b0});
        pulse_start();
        check_eq("restart_clears_err", 32'(key_err0), 32'h0);
        send_range(mk_frame(12'hA5C, 1'b0), 0, 12, 0);
        idle(3);

        // Gap timeout boundary: 64 idle cycles fail, 63 pass
        do_reset();
        push_both('{key: 12'h000, ready: 1'b0, err: 1'b1});
        pulse_start();
        send_range(mk_frame(12'hA5C, 1'b0), 0, 4, 0);
        idle(63);
        check_eq("gap63_err", 32'(key_err0), 32'h0);
        check_eq("gap63_busy", 32'(busy0), 32'h1);
        idle(1);
        check_eq("gap64_err", 32'(key_err0), 32'h1);
        idle(2);
        push_both('{key: 12'hA5C, ready: 1'b1, err: 1'b0});
        pulse_start();
        send_range(mk_frame(12'hA5C, 1'b0), 0, 4, 0);
        idle(63);
        send_range(mk_frame(12'hA5C, 1'b0), 5, 12, 0);
        idle(3);

        // Restart mid-frame, then a gappy frame
        do_reset();
        push_both('{key: 12'h3F0, ready: 1'b1, err: 1'b0});
        pulse_start();
        send_range(mk_frame(12'hFFF, 1'b0), 0, 6, 0);
        pulse_start();
        send_range(mk_frame(12'h3F0, 1'b0), 0, 12, 20);
        idle(3);

        // Reload: one-time instance keeps its key, reloadable relocks then loads
        do_reset();
        push_both('{key: 12'hA5C, ready: 1'b1, err: 1'b0});
        pulse_start();
        send_range(mk_frame(12'hA5C, 1'b0), 0, 12, 0);
        idle(3);
        q1.push_back('{key: 12'h123, ready: 1'b1, err: 1'b0});
        pulse_start();
        send_range(mk_frame(12'h123, 1'b0), 0, 3, 0);
        check_eq("reload_key1_zero", 32'(key1), 32'h0);
        check_eq("reload_ready1_low", 32'(key_ready1), 32'h0);
        check_eq("oneshot_key0_held", 32'(key0), 32'hA5C);
        send_range(mk_frame(12'h123, 1'b0), 4, 12, 0);
        idle(3);
        check_eq("oneshot_key0_final", 32'(key0), 32'hA5C);
        check_eq("oneshot_ready0_final", 32'(key_ready0), 32'h1);
        check_eq("reload_key1_final", 32'(key1), 32'h123);

        // Reset during bit 6 aborts the frame
        do_reset();
        push_both('{key: 12'h000, ready: 1'b0, err: 1'b0});
        pulse_start();
        send_range(mk_frame(12'hA5C, 1'b0), 0, 4, 0);
        sdi = 1'b1;
        sdi_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sdi_valid = 1'b0;
        check_idle_outputs("midrst");
        send_range(mk_frame(12'hA5C, 1'b0), 0, 12, 0);
        idle(2);
        check_idle_outputs("nostart");

        idle(4);
        check_eq("sb0_drained", 32'(q0.size()), 32'd0);
        check_eq("sb1_drained", 32'(q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
